// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode and format-code definitions for the immediate generator.
// Imported by the decoder and the pipeline top.
package imm_gen_pipe_pkg;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4,
      FMT_Z = 3'd5,
      FMT_R = 3'd6,
      FMT_X = 3'd7
   } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies an instruction word by opcode and
// builds the sign- (or, for CSR zimm, zero-) extended immediate.
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit LEGACY_HALF = 1'b0
) (
   input  logic [31:0]             ir,
   output logic signed [XLEN-1:0]  imm,
   output fmt_e                    fmt,
   output logic                    illegal
);

   logic signed [11:0]     f_i;
   logic signed [11:0]     f_s;
   logic signed [12:0]     f_b;
   logic signed [31:0]     f_u;
   logic signed [20:0]     f_j;
   logic        [4:0]      f_z;
   logic signed [XLEN-1:0] imm_raw;
   logic                   halve;

   // B and J fields already carry the implicit zero LSB, so they are byte offsets
   assign f_i = ir[31:20];
   assign f_s = {ir[31:25], ir[11:7]};
   assign f_b = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign f_u = {ir[31:12], 12'b0};
   assign f_j = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign f_z = ir[19:15];

   always_comb begin
      imm_raw = '0;
      fmt     = FMT_X;
      illegal = 1'b0;
      halve   = 1'b0;
      case (ir[6:0])
         OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_FENCE: begin
            fmt     = FMT_I;
            imm_raw = XLEN'(f_i);
         end
         OPCODE_STORE: begin
            fmt     = FMT_S;
            imm_raw = XLEN'(f_s);
         end
         OPCODE_BRANCH: begin
            fmt     = FMT_B;
            imm_raw = XLEN'(f_b);
         end
         OPCODE_LUI: begin
            fmt     = FMT_U;
            imm_raw = XLEN'(f_u);
         end
         OPCODE_AUIPC: begin
            fmt     = FMT_U;
            imm_raw = XLEN'(f_u);
            halve   = LEGACY_HALF;
         end
         OPCODE_JAL: begin
            fmt     = FMT_J;
            imm_raw = XLEN'(f_j);
            halve   = LEGACY_HALF;
         end
         OPCODE_SYSTEM: begin
            if (ir[14]) begin
               fmt     = FMT_Z;
               imm_raw = XLEN'(f_z);
            end else begin
               fmt     = FMT_I;
               imm_raw = XLEN'(f_i);
            end
         end
         OPCODE_OP: begin
            fmt = FMT_R;
         end
         default: begin
            fmt     = FMT_X;
            illegal = 1'b1;
         end
      endcase
   end

   // Halved form keeps the sign: the low bit dropped is always zero
   assign imm = halve ? (imm_raw >>> 1) : imm_raw;

endmodule

// File: rtl/imm_gen_pipe.sv
// Handshaked immediate generator: decoder feeding a registered output stage
// backed by a one-entry skid so upstream and downstream may stall independently.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TAG_W       = 8,
   parameter bit LEGACY_HALF = 1'b0,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_ir,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_imm,
   output logic [2:0]        out_fmt,
   output logic              out_illegal,
   output logic [TAG_W-1:0]  out_tag,
   output logic [CNT_W-1:0]  illegal_cnt
);

   logic signed [XLEN-1:0] dec_imm;
   fmt_e                   dec_fmt;
   logic                   dec_ill;

   imm_decode #(
      .XLEN        (XLEN),
      .LEGACY_HALF (LEGACY_HALF)
   ) u_dec (
      .ir      (in_ir),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   logic                   vld_p1;
   logic signed [XLEN-1:0] imm_p1;
   fmt_e                   fmt_p1;
   logic                   ill_p1;
   logic [TAG_W-1:0]       tag_p1;

   logic                   skid_vld;
   logic signed [XLEN-1:0] skid_imm;
   fmt_e                   skid_fmt;
   logic                   skid_ill;
   logic [TAG_W-1:0]       skid_tag;

   logic [CNT_W-1:0]       cnt;
   logic                   push;
   logic                   pop;
   logic                   load_out;
   logic                   load_skid;

   // in_ready comes straight from the skid flop, never from out_ready
   assign push      = in_valid & ~skid_vld & ~flush;
   assign pop       = vld_p1 & out_ready;
   assign load_out  = push & (~vld_p1 | pop);
   assign load_skid = push & vld_p1 & ~pop;

   // ---- stage p0 -> p1: output register and skid control ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         skid_vld <= 1'b0;
         imm_p1   <= '0;
         fmt_p1   <= FMT_I;
         ill_p1   <= 1'b0;
         tag_p1   <= '0;
         cnt      <= '0;
      end else if (flush) begin
         vld_p1   <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         if (pop && skid_vld) begin
            imm_p1   <= skid_imm;
            fmt_p1   <= skid_fmt;
            ill_p1   <= skid_ill;
            tag_p1   <= skid_tag;
            skid_vld <= 1'b0;
         end else if (load_out) begin
            imm_p1 <= dec_imm;
            fmt_p1 <= dec_fmt;
            ill_p1 <= dec_ill;
            tag_p1 <= in_tag;
            vld_p1 <= 1'b1;
         end else if (load_skid) begin
            skid_vld <= 1'b1;
         end else if (pop) begin
            vld_p1 <= 1'b0;
         end
         if (push && dec_ill && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Skid payload is only meaningful while skid_vld is set
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_imm <= dec_imm;
         skid_fmt <= dec_fmt;
         skid_ill <= dec_ill;
         skid_tag <= in_tag;
      end
   end

   assign in_ready    = ~skid_vld;
   assign out_valid   = vld_p1;
   assign out_imm     = imm_p1;
   assign out_fmt     = fmt_p1;
   assign out_illegal = ill_p1;
   assign out_tag     = tag_p1;
   assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance and a 64-bit halved-form instance
// with a 2-bit counter share stimulus and are checked against a queue model.
module tb_imm_gen_pipe;

   localparam int TAG_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic [31:0]       in_ir;
   logic [TAG_W-1:0]  in_tag;
   logic              out_ready;

   logic              in_ready_a, out_valid_a, ill_a;
   logic [31:0]       imm_a;
   logic [2:0]        fmt_a;
   logic [TAG_W-1:0]  tag_a;
   logic [15:0]       cnt_a;

   logic              in_ready_b, out_valid_b, ill_b;
   logic [63:0]       imm_b;
   logic [2:0]        fmt_b;
   logic [TAG_W-1:0]  tag_b;
   logic [1:0]        cnt_b;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .LEGACY_HALF(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ir(in_ir), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a),
      .illegal_cnt(cnt_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .LEGACY_HALF(1'b1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ir(in_ir), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b),
      .illegal_cnt(cnt_b)
   );

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0]      ir;
      logic [TAG_W-1:0] tag;
   } beat_t;

   int checks = 0;
   int errors = 0;
   int cnt_a_exp = 0;
   int cnt_b_exp = 0;
   beat_t q[$];

   // Reference decode from the instruction-set field layout, in plain arithmetic
   function automatic exp_t model(input logic [31:0] ir, input bit half);
      exp_t   e;
      longint v;
      v     = 0;
      e.ill = 1'b0;
      case (ir[6:0])
         7'h03, 7'h0F, 7'h13, 7'h67: begin e.fmt = 3'd0; v = longint'($signed(ir[31:20])); end
         7'h23: begin e.fmt = 3'd1; v = longint'($signed({ir[31:25], ir[11:7]})); end
         7'h63: begin e.fmt = 3'd2; v = longint'($signed({ir[31], ir[7], ir[30:25], ir[11:8]})) * 2; end
         7'h37: begin e.fmt = 3'd3; v = longint'($signed(ir[31:12])) * 4096; end
         7'h17: begin e.fmt = 3'd3; v = longint'($signed(ir[31:12])) * 4096; if (half) v = v / 2; end
         7'h6F: begin
            e.fmt = 3'd4;
            v = longint'($signed({ir[31], ir[19:12], ir[20], ir[30:21]})) * 2;
            if (half) v = v / 2;
         end
         7'h73: begin
            if (ir[14]) begin e.fmt = 3'd5; v = longint'(ir[19:15]); end
            else begin e.fmt = 3'd0; v = longint'($signed(ir[31:20])); end
         end
         7'h33: e.fmt = 3'd6;
         default: begin e.fmt = 3'd7; e.ill = 1'b1; end
      endcase
      e.imm = 64'(v);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic note_accept(input logic [31:0] ir);
      exp_t e;
      e = model(ir, 1'b0);
      if (e.ill) begin
         cnt_a_exp++;
         if (cnt_b_exp < 3) cnt_b_exp++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ir = 32'h0000007F;
      in_tag = 8'hAA; out_ready = 1'b1;
      step(); step();
      @(negedge clk);
      checks++;
      if ({out_valid_a, in_ready_a, fmt_a, ill_a, tag_a} !== {1'b0, 1'b1, 3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_ctl_a got v=%b r=%b f=%0d i=%b t=%0d want 0 1 0 0 0",
                  out_valid_a, in_ready_a, fmt_a, ill_a, tag_a);
      end
      checks++;
      if ({out_valid_b, in_ready_b, fmt_b, ill_b, tag_b} !== {1'b0, 1'b1, 3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_ctl_b got v=%b r=%b f=%0d i=%b t=%0d want 0 1 0 0 0",
                  out_valid_b, in_ready_b, fmt_b, ill_b, tag_b);
      end
      checks++;
      if (imm_a !== 32'd0 || imm_b !== 64'd0) begin
         errors++;
         $display("FAIL reset_imm got %h / %h want 0 / 0", imm_a, imm_b);
      end
      checks++;
      if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d / %0d want 0 / 0", cnt_a, cnt_b);
      end
      cnt_a_exp = 0; cnt_b_exp = 0;
      rst_n = 1'b1; in_valid = 1'b0;
      step();
   endtask

   task automatic test_decode();
      logic [31:0] irs  [12] = '{32'hFFF00093, 32'h800000B7, 32'hFE000EE3, 32'h0010006F,
                                 32'h300FD073, 32'h00000073, 32'h0000007F, 32'hFE112E23,
                                 32'h12345017, 32'h002081B3, 32'hFFFFF017, 32'h80008067};
      logic [31:0] e32  [12] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC, 32'h00000800,
                                 32'h0000001F, 32'h00000000, 32'h00000000, 32'hFFFFFFFC,
                                 32'h12345000, 32'h00000000, 32'hFFFFF000, 32'hFFFFF800};
      logic [63:0] e64  [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                 64'h0000000000000400, 64'h000000000000001F, 64'h0,
                                 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h00000000091A2800,
                                 64'h0, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFF800};
      logic [2:0]  efmt [12] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd5, 3'd0, 3'd7, 3'd1, 3'd3, 3'd6, 3'd3, 3'd0};
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_ir = irs[i]; in_tag = 8'(i + 16);
         step();
         in_valid = 1'b0;
         if (efmt[i] == 3'd7) begin cnt_a_exp++; if (cnt_b_exp < 3) cnt_b_exp++; end
         @(negedge clk);
         checks++;
         if (out_valid_a !== 1'b1 || tag_a !== 8'(i + 16) || imm_a !== e32[i] || fmt_a !== efmt[i] ||
             ill_a !== (efmt[i] == 3'd7)) begin
            errors++;
            $display("FAIL decode32 ir=%h got v=%b t=%0d imm=%h f=%0d i=%b want v=1 t=%0d imm=%h f=%0d",
                     irs[i], out_valid_a, tag_a, imm_a, fmt_a, ill_a, i + 16, e32[i], efmt[i]);
         end
         checks++;
         if (out_valid_b !== 1'b1 || imm_b !== e64[i] || fmt_b !== efmt[i] || ill_b !== (efmt[i] == 3'd7)) begin
            errors++;
            $display("FAIL decode64 ir=%h got v=%b imm=%h f=%0d i=%b want v=1 imm=%h f=%0d",
                     irs[i], out_valid_b, imm_b, fmt_b, ill_b, e64[i], efmt[i]);
         end
      end
      step();
      @(negedge clk);
      checks++;
      if (cnt_a !== 16'(cnt_a_exp) || cnt_b !== 2'(cnt_b_exp)) begin
         errors++;
         $display("FAIL decode_cnt got %0d / %0d want %0d / %0d", cnt_a, cnt_b, cnt_a_exp, cnt_b_exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [TAG_W-1:0] got[$];
      int  sent;
      bit  in_acc;
      sent = 0;
      step();
      in_valid = 1'b1; in_ir = 32'h00000013; in_tag = 8'd1;
      for (int cyc = 0; cyc < 30 && got.size() < 3; cyc++) begin
         out_ready = (cyc >= 5);
         @(negedge clk);
         if (cyc >= 2 && cyc <= 4) begin
            checks++;
            if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || tag_a !== 8'd1) begin
               errors++;
               $display("FAIL stall_hold cyc=%0d got r=%b v=%b t=%0d want r=0 v=1 t=1",
                        cyc, in_ready_a, out_valid_a, tag_a);
            end
         end
         in_acc = in_valid && in_ready_a;
         if (out_valid_a && out_ready) got.push_back(tag_a);
         step();
         if (in_acc) begin
            sent++;
            if (sent == 3) in_valid = 1'b0;
            else in_tag = 8'(sent + 1);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL order_count got %0d results want 3", got.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== 8'(k + 1)) begin
               errors++;
               $display("FAIL order_tag idx=%0d got %0d want %0d", k, got[k], k + 1);
            end
         end
      end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00000013; in_tag = 8'h40;
      step();
      in_tag = 8'h41;
      step();
      in_ir = 32'h0000007F; in_tag = 8'h42;
      @(negedge clk);
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin
         errors++;
         $display("FAIL full_state got r=%b v=%b want r=0 v=1", in_ready_a, out_valid_a);
      end
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_valid_b !== 1'b0) begin
         errors++;
         $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid_a, in_ready_a);
      end
      in_valid = 1'b1; in_ir = 32'h0000007F; in_tag = 8'h43; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0 || cnt_a !== 16'(cnt_a_exp) || cnt_b !== 2'(cnt_b_exp)) begin
         errors++;
         $display("FAIL flush_drop got v=%b cnt=%0d/%0d want v=0 cnt=%0d/%0d",
                  out_valid_a, cnt_a, cnt_b, cnt_a_exp, cnt_b_exp);
      end
      in_valid = 1'b1; in_ir = 32'h0000007F; in_tag = 8'h50;
      step();
      in_tag = 8'h51;
      step();
      note_accept(32'h0000007F); note_accept(32'h0000007F);
      @(negedge clk);
      checks++;
      if (cnt_a !== 16'(cnt_a_exp) || in_ready_a !== 1'b0) begin
         errors++;
         $display("FAIL stall_cnt got cnt=%0d r=%b want cnt=%0d r=0", cnt_a, in_ready_a, cnt_a_exp);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; in_valid = 1'b0;
      cnt_a_exp = 0; cnt_b_exp = 0;
      @(negedge clk);
      checks++;
      if ({out_valid_a, in_ready_a, imm_a, fmt_a, ill_a, tag_a, cnt_a} !==
          {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 8'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_stall got v=%b r=%b imm=%h f=%0d i=%b t=%0d c=%0d want all reset",
                  out_valid_a, in_ready_a, imm_a, fmt_a, ill_a, tag_a, cnt_a);
      end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_saturate();
      out_ready = 1'b1; in_valid = 1'b1; in_ir = 32'h0000007F;
      for (int i = 0; i < 5; i++) begin
         in_tag = 8'($urandom);
         step();
         note_accept(32'h0000007F);
         if (i == 0) begin
            @(negedge clk);
            checks++;
            if (cnt_a !== 16'd1 || cnt_b !== 2'd1 || fmt_a !== 3'd7 || ill_a !== 1'b1) begin
               errors++;
               $display("FAIL illegal_first got cnt=%0d/%0d f=%0d i=%b want 1/1 f=7 i=1",
                        cnt_a, cnt_b, fmt_a, ill_a);
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (cnt_b !== 2'd3 || cnt_a !== 16'(cnt_a_exp)) begin
         errors++;
         $display("FAIL saturate got %0d/%0d want %0d/3", cnt_a, cnt_b, cnt_a_exp);
      end
      step();
   endtask

   task automatic test_random();
      logic [6:0] opcs [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h00};
      logic [31:0] r;
      beat_t b;
      exp_t  ea, eb;
      bit    hold;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      step();
      rst_n = 1'b1;
      cnt_a_exp = 0; cnt_b_exp = 0;
      q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         checks++;
         if (out_valid_a !== (q.size() != 0) || in_ready_a !== (q.size() < 2)) begin
            errors++;
            $display("FAIL rand_occupancy cyc=%0d got v=%b r=%b want entries=%0d",
                     cyc, out_valid_a, in_ready_a, q.size());
         end
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid_a && out_ready && q.size() > 0) begin
               b  = q.pop_front();
               ea = model(b.ir, 1'b0);
               eb = model(b.ir, 1'b1);
               checks++;
               if (tag_a !== b.tag || imm_a !== ea.imm[31:0] || fmt_a !== ea.fmt || ill_a !== ea.ill ||
                   tag_b !== b.tag || imm_b !== eb.imm || fmt_b !== eb.fmt || ill_b !== eb.ill) begin
                  errors++;
                  $display("FAIL rand_result ir=%h got t=%0d %h f%0d / %h f%0d want t=%0d %h f%0d / %h f%0d",
                           b.ir, tag_a, imm_a, fmt_a, imm_b, fmt_b, b.tag, ea.imm[31:0], ea.fmt,
                           eb.imm, eb.fmt);
               end
            end
            if (in_valid && in_ready_a) begin
               b.ir = in_ir; b.tag = in_tag;
               q.push_back(b);
               note_accept(in_ir);
            end
         end
         hold = in_valid && !in_ready_a && !flush;
         step();
         flush     = ($urandom_range(0, 40) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (!hold) begin
            in_valid = ($urandom_range(0, 2) != 0);
            r = $urandom();
            r[6:0] = opcs[$urandom_range(0, 11)];
            in_ir  = r;
            in_tag = 8'($urandom);
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (cnt_a !== 16'(cnt_a_exp) || cnt_b !== 2'(cnt_b_exp)) begin
         errors++;
         $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", cnt_a, cnt_b, cnt_a_exp, cnt_b_exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
